interrupt_controller: RTL and testbench

- Consumer end of the timer-interrupt path: latches `sigint` from the quantum timer plus external request lines into pending bits.
- Arbitrates by fixed priority and presents one request to the CPU with an id.
- Handles the ack/EOI handshake and captures the interrupted PC.
- On servicing the timer source, pulses `timer_reset` back to the timer so the next quantum starts.

---
 rtl/intc_pkg.sv | 9 +
 rtl/intc_prio_enc.sv | 21 ++
 rtl/interrupt_controller.sv | 86 ++++++++
 tb/tb_interrupt_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and defaults for the interrupt controller: FSM states, timer source index, size defaults.
package intc_pkg;
  localparam int NUM_SRC_D = 4;
  localparam int ID_W_D    = 2;
  localparam int PC_W_D    = 32;
  localparam int TIMER_SRC = 0;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: eligible vector -> (valid, winning id).
module intc_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            vld,
  output logic [ID_W-1:0] id
);
  always_comb begin
    vld = 1'b0;
    id  = '0;
    // Walk from the top so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        id  = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, fixed-priority interrupt controller with ack/EOI handshake and EPC capture.
// Define TIMER_RELOAD_EN to pulse timer_reset when the timer source (0) is acked.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int PC_W    = PC_W_D,
  parameter int ID_W    = ID_W_D
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sigint,
  input  logic [NUM_SRC-2:0] ext_req,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               gie,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [PC_W-1:0]    epc,
  output logic               in_service,
  output logic               timer_reset,
  output logic [NUM_SRC-1:0] pending
);
  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] raw, raw_q, rise, eligible, ack_clr;
  logic               win_vld, take_ack;
  logic [ID_W-1:0]    win_id;

  assign raw      = {ext_req, sigint};
  assign rise     = raw & ~raw_q;
  assign eligible = pending & mask;

  intc_prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_prio (
    .req(eligible),
    .vld(win_vld),
    .id (win_id)
  );

  assign take_ack = (state == REQ) && irq_ack;
  assign ack_clr  = take_ack ? (NUM_SRC'(1) << irq_id) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gie && win_vld) state_nxt = REQ;
      // Ack wins over a same-cycle gie/mask drop: the CPU has already committed.
      REQ:     if (irq_ack) state_nxt = SERVICE;
               else if (!gie || !mask[irq_id]) state_nxt = IDLE;
      SERVICE: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      raw_q   <= '0;
      pending <= '0;
      irq_id  <= '0;
      epc     <= '0;
    end else begin
      state   <= state_nxt;
      raw_q   <= raw;
      // Set after clear so a fresh edge on the acked source survives.
      pending <= (pending & ~ack_clr) | rise;
      if (state == IDLE && state_nxt == REQ) irq_id <= win_id;
      if (take_ack) epc <= pc_in;
    end
  end

  assign irq        = (state == REQ);
  assign in_service = (state == SERVICE);

`ifdef TIMER_RELOAD_EN
  logic timer_q;
  always_ff @(posedge clock) begin
    if (reset) timer_q <= 1'b0;
    else       timer_q <= take_ack && (irq_id == ID_W'(TIMER_SRC));
  end
  assign timer_reset = timer_q;
`else
  assign timer_reset = 1'b0;
`endif
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed + randomized bench for interrupt_controller against a behavioural model.
module tb_interrupt_controller;
  logic        clock = 1'b0;
  logic        reset, sigint, gie, irq_ack, eoi;
  logic [2:0]  ext_req;
  logic [3:0]  mask;
  logic [31:0] pc_in;
  logic        irq, in_service, timer_reset;
  logic [1:0]  irq_id;
  logic [31:0] epc;
  logic [3:0]  pending;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending set, "presenting" / "servicing" flags, current id.
  bit [3:0]  m_pend, m_prev;
  bit        m_pres, m_svc, m_tr;
  int        m_id;
  bit [31:0] m_epc;

  interrupt_controller dut (
    .clock(clock), .reset(reset), .sigint(sigint), .ext_req(ext_req),
    .mask(mask), .gie(gie), .pc_in(pc_in), .irq_ack(irq_ack), .eoi(eoi),
    .irq(irq), .irq_id(irq_id), .epc(epc), .in_service(in_service),
    .timer_reset(timer_reset), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit timer_build();
`ifdef TIMER_RELOAD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit [3:0] raw, edges, elig;
    int       win;
    if (reset) begin
      m_pend = '0; m_prev = '0; m_pres = 0; m_svc = 0; m_tr = 0; m_id = 0; m_epc = '0;
      return;
    end
    raw   = {ext_req, sigint};
    edges = raw & ~m_prev;
    m_prev = raw;
    m_tr  = 0;
    if (m_pres) begin
      if (irq_ack) begin
        m_epc = pc_in;
        m_pend[m_id] = 1'b0;
        m_pres = 0;
        m_svc  = 1;
        m_tr   = timer_build() && (m_id == 0);
      end else if (!gie || !mask[m_id]) begin
        m_pres = 0;
      end
    end else if (m_svc) begin
      if (eoi) m_svc = 0;
    end else begin
      elig = m_pend & mask;
      win  = -1;
      for (int i = 0; i < 4; i++) if (elig[i] && win < 0) win = i;
      if (gie && win >= 0) begin
        m_pres = 1;
        m_id   = win;
      end
    end
    m_pend = m_pend | edges;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("irq",         32'(irq),         32'(m_pres));
    chk("irq_id",      32'(irq_id),      32'(m_id));
    chk("epc",         epc,              m_epc);
    chk("in_service",  32'(in_service),  32'(m_svc));
    chk("timer_reset", 32'(timer_reset), 32'(m_tr));
    chk("pending",     32'(pending),     32'(m_pend));
  endtask

  task automatic ack_eoi();
    irq_ack = 1; tick(); irq_ack = 0;
    eoi = 1;     tick(); eoi = 0;
  endtask

  initial begin
    reset = 1; sigint = 0; gie = 1; irq_ack = 0; eoi = 0;
    ext_req = '0; mask = 4'b1111; pc_in = '0;
    tick(); tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    reset = 0;

    // Basic timer path
    sigint = 1; tick();
    chk("t1_pend", 32'(pending), 32'h1);
    tick();
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd0);
    irq_ack = 1; pc_in = 32'h40; tick(); irq_ack = 0;
    chk("t1_epc", epc, 32'h40);
    chk("t1_insvc", 32'(in_service), 32'd1);
    chk("t1_tr", 32'(timer_reset), timer_build() ? 32'd1 : 32'd0);
    chk("t1_pend0", 32'(pending), 32'd0);
    sigint = 0; tick();
    chk("t1_tr_single", 32'(timer_reset), 32'd0);
    eoi = 1; tick(); eoi = 0;

    // Priority
    ext_req = 3'b110; tick(); tick();
    chk("t2_id2", 32'(irq_id), 32'd2);
    ack_eoi(); tick();
    chk("t2_id3", 32'(irq_id), 32'd3);
    ack_eoi(); tick();
    chk("t2_noirq", 32'(irq), 32'd0);
    ext_req = '0; tick();

    // Masking
    mask = 4'b1110; sigint = 1; tick(); tick();
    chk("t3_pend0", 32'(pending[0]), 32'd1);
    chk("t3_irq0", 32'(irq), 32'd0);
    mask = 4'b1111; tick();
    chk("t3_irq1", 32'(irq), 32'd1);
    chk("t3_id0", 32'(irq_id), 32'd0);
    irq_ack = 1; tick(); irq_ack = 0; sigint = 0;
    eoi = 1; tick(); eoi = 0;

    // Frozen id
    ext_req = 3'b100; tick(); tick();
    ext_req = 3'b101; tick(); tick();
    chk("t4_frozen", 32'(irq_id), 32'd3);
    ack_eoi(); tick();
    chk("t4_next", 32'(irq_id), 32'd1);
    ack_eoi(); ext_req = '0; tick();

    // Set-vs-clear on the acked source, and eoi in IDLE
    ext_req = 3'b010; tick(); tick();
    ext_req = 3'b000; tick();
    ext_req = 3'b010; irq_ack = 1; tick(); irq_ack = 0;
    chk("t5_setwins", 32'(pending[2]), 32'd1);
    eoi = 1; tick(); eoi = 0; tick();
    ack_eoi(); ext_req = '0; tick();
    eoi = 1; tick(); eoi = 0;
    chk("t5_eoi_idle", 32'(in_service), 32'd0);

    // Reset in SERVICE (timer source, so a stray pulse would show)
    sigint = 1; tick(); tick();
    irq_ack = 1; tick(); irq_ack = 0; sigint = 0;
    reset = 1; tick(); reset = 0;
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_svc", 32'(in_service), 32'd0);
    chk("t6_tr", 32'(timer_reset), 32'd0);
    chk("t6_epc", epc, 32'd0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (sigint) begin
        if (timer_build() ? m_tr : ($urandom_range(0, 19) == 0)) sigint = 0;
      end else if ($urandom_range(0, 9) == 0) sigint = 1;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) ext_req[b] = ~ext_req[b];
      pc_in   = $urandom;
      irq_ack = m_pres ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eoi     = m_svc  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      // Keep gie/mask steady on an acking cycle so the handshake is unambiguous.
      if (!(m_pres && irq_ack)) begin
        gie = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
